// File: rtl/ps2_pkg.sv
`default_nettype none
//------------------------------------------------------------------
// ps2_pkg - state encoding and frame constants for the PS/2 host
// Revision: 1.0
//------------------------------------------------------------------
package ps2_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_INHIBIT = 3'd1,
      S_RTS     = 3'd2,
      S_SEND    = 3'd3,
      S_ACK     = 3'd4,
      S_RELEASE = 3'd5
   } ps2_state_e;

   localparam int BIT_CNT_W  = 4;
   localparam int FRAME_BITS = 10;

   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
//------------------------------------------------------------------
// ps2_line_sync - 2-flop synchronizers for kclk/kdata, kclk fall strobe
// Revision: 1.0
//------------------------------------------------------------------
module ps2_line_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic kclk_in,
   input  logic kdata_in,
   output logic kclk_sync,
   output logic kdata_sync,
   output logic kclk_fall
);

   logic [1:0] kclk_ff;
   logic [1:0] kdata_ff;
   logic       kclk_prev;

   // Idle PS/2 lines are pulled high, so reset to 1 to avoid a false edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kclk_ff   <= 2'b11;
         kdata_ff  <= 2'b11;
         kclk_prev <= 1'b1;
      end else begin
         kclk_ff   <= {kclk_ff[0], kclk_in};
         kdata_ff  <= {kdata_ff[0], kdata_in};
         kclk_prev <= kclk_ff[1];
      end
   end

   assign kclk_sync  = kclk_ff[1];
   assign kdata_sync = kdata_ff[1];
   assign kclk_fall  = kclk_prev & ~kclk_ff[1];

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
//------------------------------------------------------------------
// ps2_host_tx - PS/2 host-to-device command byte transmitter
// Revision: 1.0
//------------------------------------------------------------------
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 10000,
   parameter int TIMEOUT_CYCLES = 1500000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   input  logic       kclk_in,
   input  logic       kdata_in,
   output logic       kclk_oe,
   output logic       kdata_oe,
   output logic       done,
   output logic       ack_ok,
   output logic       timeout,
   output logic       busy
);

   localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0]     INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0]     TIMEOUT_CNT  = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [BIT_CNT_W-1:0] LAST_BIT     = BIT_CNT_W'(FRAME_BITS - 1);

   ps2_state_e            state, state_nxt;
   logic [CNT_W-1:0]      cnt;
   logic [BIT_CNT_W-1:0]  bit_idx;
   logic [FRAME_BITS-1:0] frame;
   logic                  data_low;
   logic                  rts_second;
   logic                  ack_seen;
   logic                  kclk_s, kdata_s, kclk_fall;
   logic                  active, expired;

   ps2_line_sync u_sync (
      .clk        (clk),
      .rst_n      (rst_n),
      .kclk_in    (kclk_in),
      .kdata_in   (kdata_in),
      .kclk_sync  (kclk_s),
      .kdata_sync (kdata_s),
      .kclk_fall  (kclk_fall)
   );

   assign active  = (state == S_RTS) || (state == S_SEND) || (state == S_ACK);
   assign expired = active && (cnt == TIMEOUT_CNT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      tx_ready  = 1'b0;
      kclk_oe   = 1'b0;
      kdata_oe  = 1'b0;
      done      = 1'b0;
      ack_ok    = 1'b0;
      timeout   = 1'b0;
      busy      = 1'b1;
      case (state)
         S_IDLE: begin
            busy     = 1'b0;
            tx_ready = 1'b1;
            if (tx_valid) state_nxt = S_INHIBIT;
         end
         S_INHIBIT: begin
            kclk_oe = 1'b1;
            if (cnt == INHIBIT_LAST) state_nxt = S_RTS;
         end
         S_RTS: begin
            kdata_oe = 1'b1;
            kclk_oe  = ~rts_second;
            if (rts_second) state_nxt = S_SEND;
         end
         S_SEND: begin
            kdata_oe = data_low;
            if (kclk_fall && bit_idx == LAST_BIT) state_nxt = S_ACK;
         end
         S_ACK: begin
            if (kclk_fall) state_nxt = S_RELEASE;
         end
         S_RELEASE: begin
            if (kclk_s && kdata_s) begin
               done      = 1'b1;
               ack_ok    = ack_seen;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
      // Abort overrides everything: lines released in the same cycle as done.
      if (expired) begin
         state_nxt = S_IDLE;
         kclk_oe   = 1'b0;
         kdata_oe  = 1'b0;
         done      = 1'b1;
         ack_ok    = 1'b0;
         timeout   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt        <= '0;
         bit_idx    <= '0;
         frame      <= '0;
         data_low   <= 1'b0;
         rts_second <= 1'b0;
         ack_seen   <= 1'b0;
      end else begin
         // One counter times both the inhibit hold and the device watchdog.
         if (state == S_IDLE || (state == S_INHIBIT && state_nxt == S_RTS) || (active && kclk_fall))
            cnt <= '0;
         else if (state != S_RELEASE)
            cnt <= cnt + 1'b1;

         rts_second <= (state == S_RTS);

         if (state == S_IDLE && tx_valid) begin
            frame   <= {1'b1, odd_parity(tx_data), tx_data};
            bit_idx <= '0;
         end

         if (state == S_RTS) begin
            data_low <= 1'b1;
         end else if (state == S_SEND && kclk_fall) begin
            data_low <= ~frame[bit_idx];
            bit_idx  <= bit_idx + 1'b1;
         end

         if (state == S_ACK && kclk_fall) ack_seen <= ~kdata_s;
      end
   end

endmodule
`default_nettype wire

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 10000, clock-inhibit hold time in clk cycles (100 us at 100 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 1500000, maximum clk cycles allowed between any two expected device events (15 ms at 100 MHz).
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 tx_valid  input  1  command byte request.
REQ-006 tx_data  input  8  command byte, e.g. 0xED for set-LEDs.
REQ-007 tx_ready  output  1  high when a new byte is accepted.
REQ-008 kclk_in / kdata_in  input  1 each  raw PS/2 clock and data line levels.
REQ-009 kclk_oe / kdata_oe  output  1 each  1 = drive the line low (open-drain), 0 = release it.
REQ-010 done  output  1  one-cycle pulse at end of transfer.
REQ-011 ack_ok  output  1  valid with done: 1 = device ACK seen.
REQ-012 timeout  output  1  valid with done: 1 = transfer aborted on timeout.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 kclk_in and kdata_in SHALL pass through a 2-flop synchronizer; the falling edge of kclk is detected from the synchronized value (3-cycle input latency).
REQ-015 States: IDLE, INHIBIT, RTS, SEND, ACK, RELEASE.
REQ-016 IDLE: tx_ready=1, both _oe=0; tx_valid=1 latches tx_data, computes odd parity (parity bit = ~^tx_data), and moves to INHIBIT next cycle.
REQ-017 INHIBIT: kclk_oe=1 for exactly INHIBIT_CYCLES cycles, then RTS.
REQ-018 RTS: kdata_oe=1 on the first RTS cycle; kclk_oe=0 from the second RTS cycle; then SEND.
REQ-019 SEND: on each detected kclk falling edge, the host places the next bit: d0..d7 LSB first, parity, then stop (kdata_oe=0). Data bit value 0 -> kdata_oe=1, value 1 -> kdata_oe=0. Bit index counts 0..9; after the stop bit is placed, go to ACK.
REQ-020 ACK: on the next kclk falling edge, sample synchronized kdata; low -> ack_ok=1, high -> ack_ok=0; then RELEASE.
REQ-021 RELEASE: wait until synchronized kclk and kdata are both high, then pulse done for one cycle and return to IDLE.
REQ-022 A single timeout counter SHALL reset on entering RTS and on every detected kclk falling edge; if it reaches TIMEOUT_CYCLES in RTS, SEND or ACK, release both lines, pulse done with timeout=1, ack_ok=0, and return to IDLE.
REQ-023 tx_valid is ignored while busy; tx_ready=0 outside IDLE.
REQ-024 tx_valid in the same cycle as done is not accepted; tx_ready rises the cycle after done.
REQ-025 A kclk falling edge in IDLE, INHIBIT or RELEASE SHALL be ignored; the block never decodes device-to-host frames.
REQ-026 done, ack_ok and timeout SHALL be mutually consistent: ack_ok and timeout never both 1.

Reset
REQ-027 While rst_n=0: state=IDLE, kclk_oe=0, kdata_oe=0, tx_ready=1, done=0, ack_ok=0, timeout=0, busy=0, and counters and synchronizer flops are cleared to idle-high line levels.
REQ-028 Reset asserted mid-transfer SHALL release both lines immediately (asynchronously), with no done pulse.

Structure
REQ-029 Package ps2_pkg holds the state enumeration, the bit-count width constant and the frame length constant (10 host-driven bits).
REQ-030 One sub-module, ps2_line_sync, provides the synchronizer and the kclk falling-edge strobe for both lines; it is reusable by the receiver.

Verification
REQ-031 Send 0xED with a device model that clocks at 12.5 kHz and ACKs -> line bits 1,0,1,1,0,1,1,1, parity 1, stop 1; done with ack_ok=1.
REQ-032 Send 0x01 -> parity bit 0; send 0xFF -> parity 1; kclk_oe high for exactly INHIBIT_CYCLES cycles before kdata_oe rises.
REQ-033 Device leaves data high in the ACK slot -> done with ack_ok=0 and timeout=0.
REQ-034 Device never clocks after RTS -> done with timeout=1 exactly TIMEOUT_CYCLES cycles after RTS entry; both _oe=0.
REQ-035 rst_n low during SEND bit 4 -> both _oe=0 at once, no done; next tx_valid starts a clean frame.
REQ-036 tx_valid held high throughout two frames -> second byte accepted only the cycle after the first done.
